// File: rtl/hcsr04_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hcsr04_pkg
// Description : Shared definitions for the HC-SR04 range filter: FSM state
//               encoding, default tof width and 50 MHz scale constants, and a
//               small elaboration-time helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hcsr04_pkg;

    // Filter control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Echo counter width of the upstream driver
    localparam int DEF_TOF_W       = 16;
    // 0.00343 mm per 20 ns cycle, expressed as 225 / 2^16
    localparam int DEF_SCALE_K     = 225;
    localparam int DEF_SCALE_SHIFT = 16;

    // Larger of two integers, for sizing localparams
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : hcsr04_pkg
`default_nettype wire

// File: rtl/hcsr04_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : hcsr04_seq_mult
// Description : Unsigned shift-add multiplier, one partial product per cycle.
//               The first partial product is folded into the start cycle so
//               done pulses A_W cycles after start (product valid with done).
// Revision    : 1.0 - initial release
// ============================================================================
module hcsr04_seq_mult #(
    parameter int A_W = 16,
    parameter int B_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [A_W+B_W-1:0] product
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(A_W + 1);

    logic [P_W-1:0]   r_prod;
    logic [P_W-1:0]   r_mcand;
    logic [A_W-1:0]   r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // Load operands with the first partial product, then add one shifted multiplicand per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_prod   <= a[0] ? P_W'(b) : '0;
                r_mcand  <= P_W'(b) << 1;
                r_mplier <= a >> 1;
                r_cnt    <= CNT_W'(A_W - 1);
                r_busy   <= (A_W > 1);
                r_done   <= (A_W == 1);
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_prod;

endmodule : hcsr04_seq_mult
`default_nettype wire

// File: rtl/hcsr04_range_filter.sv
`default_nettype none
// ============================================================================
// Module      : hcsr04_range_filter
// Description : Converts HC-SR04 echo counts to millimetres with a sequential
//               multiplier and reports a moving average over 2^AVG_LOG2 shots,
//               plus sensor-fault and sticky overrun status.
//               Optional proximity alarm: define HCSR04_PROX_ALARM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hcsr04_range_filter
    import hcsr04_pkg::*;
#(
    parameter int TOF_W        = DEF_TOF_W,
    parameter int DIST_W       = 16,
    parameter int SCALE_K      = DEF_SCALE_K,
    parameter int SCALE_SHIFT  = DEF_SCALE_SHIFT,
    parameter int AVG_LOG2     = 2,
    parameter int FAULT_COUNT  = 3,
    parameter int ALARM_ON_MM  = 30,
    parameter int ALARM_OFF_MM = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TOF_W-1:0]  tof,
    input  logic              data_ready,
    input  logic              timeout_err,
    output logic [DIST_W-1:0] dist_mm,
    output logic              dist_valid,
    output logic              sensor_fault,
    output logic              overrun,
    output logic              prox_alarm
);

    localparam int K_W    = $clog2(SCALE_K + 1);
    localparam int PROD_W = TOF_W + K_W;
    localparam int WIDE_W = max_int(PROD_W, DIST_W) + 1;
    localparam int N      = 1 << AVG_LOG2;
    localparam int SUM_W  = DIST_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam int PTR_W  = max_int(AVG_LOG2, 1);
    localparam int TCNT_W = $clog2(FAULT_COUNT + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(FAULT_COUNT);
    localparam logic [K_W-1:0]    SCALE_K_V = K_W'(SCALE_K);
    localparam logic [WIDE_W-1:0] DIST_MAX  = WIDE_W'({DIST_W{1'b1}});

    state_t              r_state;
    state_t              w_next;
    logic                w_start;
    logic                w_timeout_evt;
    logic                w_acc_en;
    logic                w_out_en;
    logic                w_drop;
    logic                w_flush;

    logic                w_mult_busy;
    logic                w_mult_done;
    logic [PROD_W-1:0]   w_prod;
    logic [WIDE_W-1:0]   w_scaled;
    logic [DIST_W-1:0]   w_sample;

    logic [DIST_W-1:0]   r_buf [N];
    logic [SUM_W-1:0]    r_sum;
    logic [SUM_W-1:0]    w_evict;
    logic [FILL_W-1:0]   r_fill;
    logic [PTR_W-1:0]    r_wr;
    logic                w_full;
    logic [DIST_W-1:0]   w_avg;

    logic [TCNT_W-1:0]   r_tcnt;
    logic [TCNT_W-1:0]   w_tcnt_inc;
    logic                r_fault;
    logic                r_overrun;
    logic [DIST_W-1:0]   r_dist;
    logic                r_valid;

    hcsr04_seq_mult #(
        .A_W (TOF_W),
        .B_W (K_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .a       (tof),
        .b       (SCALE_K_V),
        .busy    (w_mult_busy),
        .done    (w_mult_done),
        .product (w_prod)
    );

    // Scale the product down to millimetres, clamping to the output range
    assign w_scaled = WIDE_W'(w_prod) >> SCALE_SHIFT;
    assign w_sample = (w_scaled > DIST_MAX) ? {DIST_W{1'b1}} : w_scaled[DIST_W-1:0];

    // Only a full window holds an entry that belongs in the running sum
    assign w_full  = (r_fill == FILL_FULL);
    assign w_evict = w_full ? SUM_W'(r_buf[r_wr]) : '0;
    assign w_avg   = DIST_W'(r_sum >> AVG_LOG2);

    assign w_tcnt_inc = (r_tcnt == TCNT_MAX) ? r_tcnt : r_tcnt + 1'b1;
    assign w_flush    = w_timeout_evt && (w_tcnt_inc == TCNT_MAX);
    assign w_drop     = (r_state != ST_IDLE) && (data_ready || timeout_err);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control strobes; timeouts win over new samples
    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_timeout_evt = 1'b0;
        w_acc_en      = 1'b0;
        w_out_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (timeout_err) begin
                    w_timeout_evt = 1'b1;
                end else if (data_ready && !w_mult_busy) begin
                    w_start = 1'b1;
                    w_next  = ST_MUL;
                end
            end
            ST_MUL: begin
                if (w_mult_done) begin
                    w_next = ST_ACC;
                end
            end
            ST_ACC: begin
                w_acc_en = 1'b1;
                w_next   = ST_OUT;
            end
            ST_OUT: begin
                w_out_en = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Consecutive-timeout counter and fault flag; any good sample clears both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt  <= '0;
            r_fault <= 1'b0;
        end else if (w_timeout_evt) begin
            r_tcnt <= w_tcnt_inc;
            if (w_tcnt_inc == TCNT_MAX) begin
                r_fault <= 1'b1;
            end
        end else if (w_start) begin
            r_tcnt  <= '0;
            r_fault <= 1'b0;
        end
    end

    // Circular window and running sum; a fault flush restarts filling from slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
            r_sum  <= '0;
            r_fill <= '0;
            r_wr   <= '0;
        end else if (w_flush) begin
            r_sum  <= '0;
            r_fill <= '0;
            r_wr   <= '0;
        end else if (w_acc_en) begin
            r_sum       <= r_sum - w_evict + SUM_W'(w_sample);
            r_buf[r_wr] <= w_sample;
            r_wr        <= (r_wr == PTR_LAST) ? '0 : r_wr + 1'b1;
            if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Publish the window average only once the window is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dist  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_out_en && w_full) begin
                r_dist  <= w_avg;
                r_valid <= 1'b1;
            end
        end
    end

    // Sticky flag for pulses that arrive while a sample is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign dist_mm      = r_dist;
    assign dist_valid   = r_valid;
    assign sensor_fault = r_fault;
    assign overrun      = r_overrun;

`ifdef HCSR04_PROX_ALARM_EN
    localparam logic [DIST_W-1:0] ALARM_ON_V  = DIST_W'(ALARM_ON_MM);
    localparam logic [DIST_W-1:0] ALARM_OFF_V = DIST_W'(ALARM_OFF_MM);

    logic r_alarm;

    // Hysteretic alarm evaluated against each freshly published average
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else if (w_out_en && w_full) begin
            if (w_avg < ALARM_ON_V) begin
                r_alarm <= 1'b1;
            end else if (w_avg >= ALARM_OFF_V) begin
                r_alarm <= 1'b0;
            end
        end
    end

    // A dead sensor cannot vouch for clearance, so treat it as an obstacle
    assign prox_alarm = r_alarm | r_fault;
`else
    // Thresholds are inert without the alarm; an inverted band elaborates nothing extra
    if (ALARM_ON_MM > ALARM_OFF_MM) begin : g_alarm_band_inverted
    end

    assign prox_alarm = 1'b0;
`endif

endmodule : hcsr04_range_filter
`default_nettype wire

// File: tb/tb_hcsr04_range_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hcsr04_range_filter
// Description : Self-checking bench for hcsr04_range_filter: a shot-level
//               model (sample window queue, event timing) checked every cycle,
//               plus directed shots with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hcsr04_range_filter;

    localparam int TOF_W = 16;
    localparam int N     = 4;
    localparam int LAT   = TOF_W + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tof = '0;
    logic        data_ready = 1'b0;
    logic        timeout_err = 1'b0;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        sensor_fault;
    logic        overrun;
    logic        prox_alarm;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    hcsr04_range_filter dut (
        .clk          (clk),
        .rst          (rst),
        .tof          (tof),
        .data_ready   (data_ready),
        .timeout_err  (timeout_err),
        .dist_mm      (dist_mm),
        .dist_valid   (dist_valid),
        .sensor_fault (sensor_fault),
        .overrun      (overrun),
        .prox_alarm   (prox_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- shot-level model ----------------
    int m_edge = 0;
    bit m_pending = 1'b0;
    int m_done_edge = 0;
    int m_pend_sample = 0;
    int m_win[$];
    int m_tcnt = 0;
    bit m_fault = 1'b0;
    bit m_overrun = 1'b0;
    bit m_valid = 1'b0;
    bit m_alarm = 1'b0;
    int m_dist = 0;

    function automatic int to_mm(input int t);
        longint p;
        p = (longint'(t) * 225) >>> 16;
        if (p > 65535) p = 65535;
        return int'(p);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edge = 0; m_pending = 0; m_tcnt = 0; m_fault = 0;
            m_overrun = 0; m_valid = 0; m_alarm = 0; m_dist = 0;
            m_win.delete();
        end else begin
            m_edge++;
            m_valid = 0;
            if (data_ready || timeout_err) begin
                if (m_pending) begin
                    m_overrun = 1;
                end else if (timeout_err) begin
                    if (m_tcnt < 3) m_tcnt++;
                    if (m_tcnt == 3) begin
                        m_fault = 1;
                        m_win.delete();
                    end
                end else begin
                    m_tcnt = 0;
                    m_fault = 0;
                    m_pending = 1;
                    m_done_edge = m_edge + LAT;
                    m_pend_sample = to_mm(int'(tof));
                end
            end
            if (m_pending && m_edge == m_done_edge) begin
                int s;
                m_pending = 0;
                m_win.push_back(m_pend_sample);
                if (m_win.size() > N) void'(m_win.pop_front());
                if (m_win.size() == N) begin
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    m_dist = s / N;
                    m_valid = 1;
                    if (m_dist < 30) m_alarm = 1;
                    else if (m_dist >= 40) m_alarm = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int exp_prox;
`ifdef HCSR04_PROX_ALARM_EN
            exp_prox = (m_fault || m_alarm) ? 1 : 0;
`else
            exp_prox = 0;
`endif
            chk("cyc_dist_valid", int'(dist_valid), int'(m_valid));
            chk("cyc_dist_mm", int'(dist_mm), m_dist);
            chk("cyc_sensor_fault", int'(sensor_fault), int'(m_fault));
            chk("cyc_overrun", int'(overrun), int'(m_overrun));
            chk("cyc_prox_alarm", int'(prox_alarm), exp_prox);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic shot(input int t, input bit exp_v, input int exp_mm);
        bit seen;
        int seen_k;
        @(posedge clk); #1;
        data_ready = 1'b1;
        tof = t[15:0];
        @(posedge clk); #1;
        data_ready = 1'b0;
        seen = 0;
        seen_k = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (dist_valid && !seen) begin
                seen = 1;
                seen_k = k;
                chk("shot_dist_mm", int'(dist_mm), exp_mm);
            end
        end
        chk("shot_valid_seen", int'(seen), int'(exp_v));
        if (exp_v) chk("shot_latency", seen_k, LAT);
    endtask

    task automatic timeout_pulse();
        @(posedge clk); #1;
        timeout_err = 1'b1;
        @(posedge clk); #1;
        timeout_err = 1'b0;
    endtask

    task automatic chk_prox(input string name, input int req);
`ifdef HCSR04_PROX_ALARM_EN
        chk(name, int'(prox_alarm), req);
`else
        chk(name, int'(prox_alarm), 0);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_dist_mm", int'(dist_mm), 0);
        chk("rst_dist_valid", int'(dist_valid), 0);
        chk("rst_fault", int'(sensor_fault), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_prox", int'(prox_alarm), 0);

        // Window fill: only the fourth shot publishes
        shot(10000, 0, 0);
        shot(10000, 0, 0);
        shot(10000, 0, 0);
        shot(10000, 1, 34);
        chk_prox("prox_at_34", 0);

        // Mixed samples 13, 27, 41, 54 then 54
        shot(4000, 1, 28);
        chk_prox("prox_at_28", 1);
        shot(8000, 1, 27);
        shot(12000, 1, 28);
        shot(16000, 1, 33);
        chk_prox("prox_at_33", 1);
        shot(16000, 1, 44);
        chk_prox("prox_at_44", 0);

        // Three timeouts raise the fault and flush the window
        timeout_pulse();
        timeout_pulse();
        @(negedge clk);
        chk("fault_after_2", int'(sensor_fault), 0);
        timeout_pulse();
        @(negedge clk);
        chk("fault_after_3", int'(sensor_fault), 1);
        chk("dist_hold_fault", int'(dist_mm), 44);
        chk_prox("prox_forced_fault", 1);

        // Recovery needs a full window of new samples
        shot(8000, 0, 0);
        chk("fault_cleared", int'(sensor_fault), 0);
        shot(8000, 0, 0);
        shot(8000, 0, 0);
        shot(8000, 1, 27);
        chk_prox("prox_at_27", 1);

        // 11651 maps to exactly 40 mm: band edges 30 (hold) and 40 (clear)
        shot(11651, 1, 30);
        chk_prox("prox_at_30", 1);
        shot(11651, 1, 33);
        shot(11651, 1, 36);
        shot(11651, 1, 40);
        chk_prox("prox_at_40", 0);

        // Full-scale tof: 65535 -> 224 mm
        shot(65535, 1, 86);

        // Second pulse five cycles into the multiply is dropped
        @(posedge clk); #1;
        data_ready = 1'b1;
        tof = 16'd4000;
        @(posedge clk); #1;
        data_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 data_ready = 1'b1;
        tof = 16'd60000;
        @(posedge clk); #1;
        data_ready = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (dist_valid && !seen) begin
                    seen = 1;
                    chk("overrun_dist_mm", int'(dist_mm), 79);
                end
            end
            chk("overrun_valid_seen", int'(seen), 1);
        end
        chk("overrun_set", int'(overrun), 1);
        repeat (3) @(posedge clk);
        #1 chk("overrun_sticky", int'(overrun), 1);

        // Asynchronous reset during a multiply
        @(posedge clk); #1;
        data_ready = 1'b1;
        tof = 16'd10000;
        @(posedge clk); #1;
        data_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_dist_mm", int'(dist_mm), 0);
        chk("async_rst_overrun", int'(overrun), 0);
        chk("async_rst_fault", int'(sensor_fault), 0);
        chk("async_rst_valid", int'(dist_valid), 0);
        chk("async_rst_prox", int'(prox_alarm), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        shot(10000, 0, 0);
        shot(10000, 0, 0);
        shot(10000, 0, 0);
        shot(10000, 1, 34);
        chk("overrun_after_rst", int'(overrun), 0);

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not complete");
    end

endmodule : tb_hcsr04_range_filter
`default_nettype wire

// File: doc/hcsr04_range_filter.md
Name: hcsr04_range_filter

Overview:
Downstream consumer of the HC-SR04 driver. Takes the per-shot tof count, data_ready and timeout_err pulses, converts tof to millimetres with a sequential shift-add multiplier, and averages the result over a power-of-two window. It outputs a filtered distance with a valid strobe, plus sensor-fault and overrun status, for control logic and display.

Parameters:
TOF_W, 16, width of tof input (matches driver tof width)
DIST_W, 16, width of distance outputs in mm
SCALE_K, 225, mm-per-cycle scale in Q0.SCALE_SHIFT (0.00343 mm/cycle at 50 MHz)
SCALE_SHIFT, 16, right shift applied to tof*SCALE_K
AVG_LOG2, 2, log2 of averaging window (window N = 4)
FAULT_COUNT, 3, consecutive timeouts that raise sensor_fault
ALARM_ON_MM, 30, alarm set threshold (optional feature only)
ALARM_OFF_MM, 40, alarm clear threshold (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
tof  in  TOF_W  echo width from driver, valid when data_ready=1
data_ready  in  1  one-cycle pulse, new good sample
timeout_err  in  1  one-cycle pulse, shot timed out
dist_mm  out  DIST_W  windowed average distance, mm
dist_valid  out  1  one-cycle pulse when dist_mm updates
sensor_fault  out  1  level, FAULT_COUNT consecutive timeouts seen
overrun  out  1  sticky, input pulse arrived while busy
prox_alarm  out  1  hysteretic proximity alarm (0 when feature off)

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; buffer, sum, fill count, timeout count cleared.
- FSM states: IDLE, MUL, ACC, OUT.
- IDLE, timeout_err=1: increment timeout count (saturating at FAULT_COUNT); at FAULT_COUNT set sensor_fault, clear fill count and sum. Stay IDLE. timeout_err has priority if both inputs are high.
- IDLE, data_ready=1: latch tof, clear timeout count, clear sensor_fault, go to MUL.
- MUL: TOF_W cycles, one shift-add step per cycle. Product width is TOF_W+$clog2(SCALE_K+1). Sample distance = product >> SCALE_SHIFT, saturated to DIST_W all-ones.
- ACC: one cycle. sum <= sum - buf[wr_ptr] + sample; buf[wr_ptr] <= sample; wr_ptr wraps modulo N; fill count saturates at N. Sum width is DIST_W+AVG_LOG2, so it never overflows.
- OUT: one cycle. If fill count == N: dist_mm <= sum >> AVG_LOG2 (truncate) and dist_valid pulses. Otherwise there is no pulse and dist_mm holds. Return to IDLE.
- Latency: data_ready sampled at edge 0; dist_valid high for exactly the cycle following edge TOF_W+2.
- dist_mm holds its last value between updates and across a sensor fault.
- A data_ready or timeout_err pulse outside IDLE is dropped and sets overrun. overrun clears only on reset.
- After a fault flush, N new good samples are needed before the next dist_valid.
- Buffer entries are not zeroed on flush; fill count and sum gating make stale entries irrelevant. Sum is cleared and buffer write order restarts at wr_ptr 0.

Optional Feature:
Macro HCSR04_PROX_ALARM_EN.
- Defined: on each dist_valid, prox_alarm sets when the new dist_mm < ALARM_ON_MM and clears when dist_mm >= ALARM_OFF_MM; otherwise it holds. sensor_fault forces prox_alarm=1.
- Undefined: no alarm logic is synthesized and prox_alarm is tied to 0.

Decomposition:
- Shared package hcsr04_pkg: FSM state encoding, default SCALE_K/SCALE_SHIFT for 50 MHz, default TOF_W.
- One sub-module, hcsr04_seq_mult: start/busy/done shift-add unsigned multiplier, parameterized operand widths, TOF_W-cycle latency.

Test Plan:
- Reset mid-MUL: assert rst during the multiply -> all outputs 0 immediately; next 4 samples needed before dist_valid.
- Four samples tof=10000 -> no dist_valid on samples 1-3; dist_valid on the 4th with dist_mm=34, exactly TOF_W+2 edges after data_ready.
- tof 4000, 8000, 12000, 16000 (per-sample 13, 27, 41, 54) -> dist_mm=33; a fifth sample of 16000 -> (27+41+54+54)>>2 = 44.
- Three timeout_err pulses after a filled window -> sensor_fault=1 after the 3rd, dist_mm holds; next data_ready clears the fault; dist_valid only after 4 new samples.
- data_ready pulsed 5 cycles after the previous one -> second pulse ignored, overrun=1 and stays 1; first sample still processed.
- HCSR04_PROX_ALARM_EN defined: averages 34, 28, 35, 40 -> prox_alarm 0, 1, 1, 0; macro undefined -> prox_alarm constant 0.
